pc_seq: RTL
===========

// Module: pc_seq
// PURPOSE
//  Parametrised program counter for the single-cycle datapath. Generalises the 8-bit free-running PC:
//  - configurable width
//  - stall (enable)
//  - absolute jump and PC-relative branch
//  - call/return via a return-address stack (RAS)
//  Drives the instruction-memory address. Takes control from the decode stage.
// PARAMETERS
//  WIDTH        8   PC / address width in bits
//  STACK_DEPTH  4   RAS entries (>=1)
//  RESET_VEC    0   PC value loaded on reset (WIDTH bits)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high reset
//  en           in   1      1 = advance per op this cycle; 0 = stall (hold everything)
//  op           in   3      pc_op_e: INC=0, JUMP=1, BRANCH=2, CALL=3, RET=4; 5..7 reserved
//  target       in   WIDTH  absolute destination for JUMP/CALL
//  offset       in   WIDTH  two's-complement displacement for BRANCH
//  PC           out  WIDTH  current program counter (registered)
//  stack_empty  out  1      RAS holds 0 entries
//  stack_full   out  1      RAS holds STACK_DEPTH entries
//  fault        out  1      1-cycle pulse: CALL on full or RET on empty
// BEHAVIOUR
//  - Reset (async assert, takes effect immediately):
//    - PC=RESET_VEC, sp=0, stack_empty=1, stack_full=0, fault=0.
//    - RAS contents are don't-care.
//    - Reset mid-operation discards any pending call/return state.
//  - All state updates on the rising clk edge when reset=0. PC reflects the op sampled at the previous edge (1-cycle latency).
//  - en=0: PC, sp and RAS are held; op is ignored; fault=0 next cycle.
//  - en=1, by op:
//    - INC: PC <= PC+1, modulo 2^WIDTH (all-ones wraps to 0).
//    - JUMP: PC <= target.
//    - BRANCH: PC <= PC+offset, modulo 2^WIDTH (offset sign-extended; e.g. -2 = all-ones-1).
//    - CALL, not full: RAS[sp] <= PC+1 (wrapped); sp++; PC <= target.
//    - CALL, full: no push; PC <= PC+1; fault=1 for one cycle.
//    - RET, not empty: PC <= RAS[sp-1]; sp--.
//    - RET, empty: PC <= PC+1; fault=1 for one cycle.
//    - reserved (5..7): behaves as INC; no fault.
//  - sp is a 0..STACK_DEPTH counter ($clog2(STACK_DEPTH+1) bits), never wraps.
//  - stack_empty = (sp==0); stack_full = (sp==STACK_DEPTH). Both derive from registered sp, so they update with PC.
//  - fault is registered: high exactly in the cycle after the offending edge. It is cleared on the next edge unless the fault repeats.
//  - Only one op per cycle; push and pop never coincide.
// STRUCTURE
//  - pc_pkg: typedef enum logic [2:0] pc_op_e {PC_INC, PC_JUMP, PC_BRANCH, PC_CALL, PC_RET}. Shared with decode.
//  - Sub-module pc_ras (params WIDTH, STACK_DEPTH):
//    - inputs: push, pop, din
//    - outputs: dout (top), empty, full
//    - reset clears only sp.
//  - pc_seq: PC register, next-PC mux, fault register.
// TESTING (WIDTH=8, STACK_DEPTH=4, RESET_VEC=0)
//  1. Reset and wrap:
//     - reset=1 -> PC=0, empty=1.
//     - Release, en=1, op=INC, 255 edges -> PC=255; next edge -> PC=0.
//  2. Stall, jump and branch:
//     - en=0 for 3 edges -> PC unchanged.
//     - JUMP target=0x40 -> 0x40.
//     - BRANCH offset=0xFE -> 0x3E.
//     - BRANCH offset=0x05 -> 0x43.
//  3. Call/return:
//     - PC=0x10, CALL target=0x80 -> PC=0x80, empty=0.
//     - INC x2 -> 0x82.
//     - RET -> PC=0x11, empty=1.
//  4. Overflow:
//     - 4 nested CALLs -> full=1.
//     - 5th CALL -> PC=PC+1, fault=1 one cycle, sp stays 4.
//     - 4 RETs return addresses in LIFO order.
//  5. Underflow:
//     - RET with empty=1 at PC=0x20 -> PC=0x21, fault=1 for one cycle, then 0.
//  6. Reset mid-operation:
//     - 2 CALLs, then reset asserted between edges -> PC=0 immediately, empty=1, fault=0.
//     - A following RET faults.

Source files
------------

// File: rtl/pc_pkg.sv
// Program-counter operation encoding, shared between decode and the PC sequencer.
package pc_pkg;

  // Codes 5..7 are reserved; the sequencer treats them as PC_INC.
  typedef enum logic [2:0] {
    PC_INC    = 3'd0,
    PC_JUMP   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4
  } pc_op_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack for the PC sequencer.
// Ports:
//   clk, reset  rising-edge clock, asynchronous active-high reset (clears sp only)
//   push, pop   push din / pop the top entry (never both in one cycle)
//   din         return address to push
//   dout        current top entry (undefined while empty)
//   empty, full stack pointer at 0 / at STACK_DEPTH
module pc_ras #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned SpW   = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AddrW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SpW-1:0]   sp_q, sp_d;
  logic [AddrW-1:0] wr_idx, top_idx;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [2**AddrW];

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SpW'(STACK_DEPTH));
  // Guard locally as well so sp can never wrap even if a caller misbehaves.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_idx  = AddrW'(sp_q);
  assign top_idx = AddrW'(sp_q - SpW'(1));
  assign dout    = mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (do_push) begin
      sp_d = sp_q + SpW'(1);
    end else if (do_pop) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage is not reset; contents above sp are don't-care.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Parametrised program counter with stall, jump, relative branch and call/return.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   en           1 = apply op this cycle, 0 = hold all state
//   op           pc_op_e operation code (5..7 act as increment)
//   target       absolute destination for JUMP/CALL
//   offset       two's-complement displacement for BRANCH
//   PC           registered program counter (instruction-memory address)
//   stack_empty  return-address stack holds no entries
//   stack_full   return-address stack holds STACK_DEPTH entries
//   fault        one-cycle pulse after CALL on full or RET on empty
module pc_seq
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] PC,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             fault
);

  logic [WIDTH-1:0] pc_q, pc_d, pc_plus1, ras_top;
  logic             fault_q, fault_d;
  logic             push, pop, ras_empty, ras_full;

  assign pc_plus1 = pc_q + WIDTH'(1);

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    fault_d = 1'b0;
    if (en) begin
      case (op)
        PC_JUMP:   pc_d = target;
        PC_BRANCH: pc_d = pc_q + offset;  // same width, so wraps modulo 2^WIDTH
        PC_CALL: begin
          if (ras_full) begin
            pc_d    = pc_plus1;
            fault_d = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = target;
          end
        end
        PC_RET: begin
          if (ras_empty) begin
            pc_d    = pc_plus1;
            fault_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = ras_top;
          end
        end
        default:   pc_d = pc_plus1;  // INC and reserved codes
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VEC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  pc_ras #(
    .WIDTH      (WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ras (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (pc_plus1),
    .dout (ras_top),
    .empty(ras_empty),
    .full (ras_full)
  );

  assign PC          = pc_q;
  assign stack_empty = ras_empty;
  assign stack_full  = ras_full;
  assign fault       = fault_q;

endmodule
